// File: rtl/rggen_register_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : rggen_register_access_controller
// Brief    : Bus-side front end for bit-field stages. Accepts one register
//            access at a time, decodes the byte address, issues a one-cycle
//            bit-field strobe and returns read data with an OKAY/ERROR status.
// Revision : 1.0 - initial release
// ============================================================================
module rggen_register_access_controller #(
    parameter int          WIDTH         = 32,
    parameter int          REGISTERS     = 4,
    parameter int          ADDRESS_WIDTH = 8,
    parameter int unsigned BASE_ADDRESS  = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_request_valid,
    output logic                       o_request_ready,
    input  logic [ADDRESS_WIDTH-1:0]   i_address,
    input  logic                       i_write,
    input  logic [WIDTH-1:0]           i_write_data,
    input  logic [WIDTH/8-1:0]         i_strobe,
    output logic                       o_response_valid,
    input  logic                       i_response_ready,
    output logic [WIDTH-1:0]           o_read_data,
    output logic                       o_error,
    output logic                       o_bit_field_valid,
    output logic [REGISTERS-1:0]       o_select,
    output logic [WIDTH-1:0]           o_read_mask,
    output logic [WIDTH-1:0]           o_write_mask,
    output logic [WIDTH-1:0]           o_write_data,
    input  logic [REGISTERS*WIDTH-1:0] i_read_data
);

    localparam int                     c_BYTES       = WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] c_BASE      = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] c_BYTES_A   = ADDRESS_WIDTH'(c_BYTES);
    localparam logic [ADDRESS_WIDTH:0]   c_REGS_EXT  = (ADDRESS_WIDTH+1)'(REGISTERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e                     r_state;
    state_e                     w_next_state;

    logic [ADDRESS_WIDTH-1:0]   r_address;
    logic                       r_write;
    logic [WIDTH-1:0]           r_write_data;
    logic [c_BYTES-1:0]         r_strobe;
    logic [WIDTH-1:0]           r_read_data;
    logic                       r_error;

    logic [ADDRESS_WIDTH-1:0]   w_offset;
    logic [ADDRESS_WIDTH-1:0]   w_index;
    logic                       w_underflow;
    logic                       w_in_range;
    logic                       w_misaligned;
    logic                       w_error;
    logic [REGISTERS-1:0]       w_onehot;
    logic [WIDTH-1:0]           w_selected;
    logic [WIDTH-1:0]           w_strobe_mask;
    logic                       w_accept;

    // Address decode works on the captured address so that strobe-time
    // outputs never depend combinationally on the request channel.
    assign w_offset     = r_address - c_BASE;
    assign w_index      = w_offset / c_BYTES_A;
    assign w_underflow  = (r_address < c_BASE);
    assign w_in_range   = ({1'b0, w_index} < c_REGS_EXT);
    assign w_misaligned = ((w_offset % c_BYTES_A) != '0);
    assign w_error      = w_underflow | ~w_in_range | w_misaligned;

    generate
        for (genvar k = 0; k < REGISTERS; k++) begin : g_select
            assign w_onehot[k] = (w_index == ADDRESS_WIDTH'(k)) & w_in_range;
        end
        for (genvar b = 0; b < c_BYTES; b++) begin : g_write_mask
            assign w_strobe_mask[b*8 +: 8] = {8{r_strobe[b]}};
        end
    endgenerate

    // Read-data mux: OR of the slices gated by the one-hot select.
    always_comb begin
        w_selected = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (w_onehot[k]) begin
                w_selected = w_selected | i_read_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept = o_request_ready & i_request_valid;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and strobe-side outputs, all derived from registers.
    always_comb begin
        w_next_state      = r_state;
        o_request_ready   = 1'b0;
        o_response_valid  = 1'b0;
        o_bit_field_valid = 1'b0;
        o_select          = '0;
        o_read_mask       = '0;
        o_write_mask      = '0;
        case (r_state)
            IDLE: begin
                o_request_ready = ~i_rst;
                if (i_request_valid) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                o_bit_field_valid = ~w_error;
                if (!w_error) begin
                    o_select = w_onehot;
                end
                if (r_write) begin
                    o_write_mask = w_strobe_mask;
                end else begin
                    o_read_mask = '1;
                end
                w_next_state = RESPOND;
            end
            RESPOND: begin
                o_response_valid = 1'b1;
                if (i_response_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request capture on the accepting edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_address    <= '0;
            r_write      <= 1'b0;
            r_write_data <= '0;
            r_strobe     <= '0;
        end else if (w_accept) begin
            r_address    <= i_address;
            r_write      <= i_write;
            r_write_data <= i_write_data;
            r_strobe     <= i_strobe;
        end
    end

    // Response capture at the end of ACCESS (pre-update field value), cleared
    // once the response has been consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_read_data <= '0;
            r_error     <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_read_data <= (!r_write && !w_error) ? w_selected : '0;
            r_error     <= w_error;
        end else if ((r_state == RESPOND) && i_response_ready) begin
            r_read_data <= '0;
            r_error     <= 1'b0;
        end
    end

    assign o_read_data  = r_read_data;
    assign o_error      = r_error;
    assign o_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_rggen_register_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rggen_register_access_controller
// Brief    : Directed self-checking bench for the register access controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rggen_register_access_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [7:0]   address;
    logic         write;
    logic [31:0]  wdata;
    logic [3:0]   strobe;
    logic         resp_ready;
    logic [127:0] rd_in = {32'h4444_4444, 32'h0000_00F0, 32'h2222_2222, 32'h1111_1111};

    logic         req_ready, resp_valid, err, bfv;
    logic [31:0]  rdata, rmask, wmask, wdata_o;
    logic [3:0]   sel;
    logic         b_req_ready, b_resp_valid, b_err, b_bfv;
    logic [31:0]  b_rdata, b_rmask, b_wmask, b_wdata_o;
    logic [3:0]   b_sel;

    int vectors     = 0;
    int miscompares = 0;
    int bfv_count   = 0;
    logic bfv_prev  = 1'b0;
    logic b2b_seen  = 1'b0;

    // Observations captured by issue()
    logic        a_bfv, a_b_bfv;
    logic [3:0]  a_sel;
    logic [31:0] a_rm, a_wm, a_wd;
    logic        r_valid, r_err, r_b_err, r_ready_after;
    logic [31:0] r_rd, r_b_rd;
    int          bfv_delta;

    always #5 clk = ~clk;

    rggen_register_access_controller #(
        .WIDTH(32), .REGISTERS(4), .ADDRESS_WIDTH(8), .BASE_ADDRESS(0)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_request_valid(req_valid), .o_request_ready(req_ready),
        .i_address(address), .i_write(write), .i_write_data(wdata), .i_strobe(strobe),
        .o_response_valid(resp_valid), .i_response_ready(resp_ready),
        .o_read_data(rdata), .o_error(err),
        .o_bit_field_valid(bfv), .o_select(sel),
        .o_read_mask(rmask), .o_write_mask(wmask), .o_write_data(wdata_o),
        .i_read_data(rd_in)
    );

    rggen_register_access_controller #(
        .WIDTH(32), .REGISTERS(4), .ADDRESS_WIDTH(8), .BASE_ADDRESS(32'h20)
    ) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_request_valid(req_valid), .o_request_ready(b_req_ready),
        .i_address(address), .i_write(write), .i_write_data(wdata), .i_strobe(strobe),
        .o_response_valid(b_resp_valid), .i_response_ready(resp_ready),
        .o_read_data(b_rdata), .o_error(b_err),
        .o_bit_field_valid(b_bfv), .o_select(b_sel),
        .o_read_mask(b_rmask), .o_write_mask(b_wmask), .o_write_data(b_wdata_o),
        .i_read_data(rd_in)
    );

    // Register 2 behaves as a read-clear field.
    always @(posedge clk) begin
        if (bfv && sel[2] && rmask[0]) rd_in[95:64] <= 32'h0;
    end

    // Strobe counter and back-to-back strobe detector.
    always @(negedge clk) begin
        if (bfv) bfv_count <= bfv_count + 1;
        if (bfv && bfv_prev) b2b_seen <= 1'b1;
        bfv_prev <= bfv;
    end

    task automatic issue(input logic [7:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s);
        int c0;
        @(negedge clk);
        req_valid = 1'b1; address = a; write = w; wdata = d; strobe = s;
        c0 = bfv_count;
        @(negedge clk);
        req_valid = 1'b0;
        a_bfv = bfv; a_sel = sel; a_rm = rmask; a_wm = wmask; a_wd = wdata_o; a_b_bfv = b_bfv;
        @(negedge clk);
        r_valid = resp_valid; r_rd = rdata; r_err = err; r_b_rd = b_rdata; r_b_err = b_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        r_ready_after = req_ready;
        bfv_delta = bfv_count - c0;
    endtask

    task automatic test_reset;
        logic seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %h want 1", req_ready); end
        vectors++; if ({resp_valid, bfv, err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {resp_valid, bfv, err}); end
        vectors++; if ({sel, rmask, wmask, rdata, wdata_o} !== '0) begin miscompares++; $display("FAIL reset_data: sel %h rm %h wm %h rd %h wd %h want all 0", sel, rmask, wmask, rdata, wdata_o); end
        // Reset in the middle of an ACCESS cycle
        @(negedge clk);
        req_valid = 1'b1; address = 8'h0C; write = 1'b1; wdata = 32'hDEAD_BEEF; strobe = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (bfv !== 1'b1 || sel !== 4'b1000) begin miscompares++; $display("FAIL rst_pre_access: bfv %h sel %b want 1 1000", bfv, sel); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({bfv, sel, wmask, rmask, wdata_o, resp_valid} !== '0) begin miscompares++; $display("FAIL rst_mid_access: bfv %h sel %b wm %h rm %h wd %h rv %h want all 0", bfv, sel, wmask, rmask, wdata_o, resp_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %h want 1", req_ready); end
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (resp_valid || bfv) seen = 1'b1; end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_no_response: got %h want 0", seen); end
    endtask

    task automatic test_write;
        issue(8'h04, 1'b1, 32'hA5A5_1234, 4'b0101);
        vectors++; if (a_bfv !== 1'b1 || a_sel !== 4'b0010) begin miscompares++; $display("FAIL write_strobe: bfv %h sel %b want 1 0010", a_bfv, a_sel); end
        vectors++; if (a_wm !== 32'h00FF_00FF || a_rm !== 32'h0) begin miscompares++; $display("FAIL write_masks: wm %h rm %h want 00ff00ff 0", a_wm, a_rm); end
        vectors++; if (a_wd !== 32'hA5A5_1234) begin miscompares++; $display("FAIL write_data: got %h want a5a51234", a_wd); end
        vectors++; if (r_valid !== 1'b1 || r_err !== 1'b0 || r_rd !== 32'h0) begin miscompares++; $display("FAIL write_resp: valid %h err %h rd %h want 1 0 0", r_valid, r_err, r_rd); end
        vectors++; if (bfv_delta !== 1 || r_ready_after !== 1'b1) begin miscompares++; $display("FAIL write_count: strobes %0d ready %h want 1 1", bfv_delta, r_ready_after); end
        // No-op write still strobes
        issue(8'h0C, 1'b1, 32'h1234_5678, 4'b0000);
        vectors++; if (a_bfv !== 1'b1 || a_sel !== 4'b1000 || a_wm !== 32'h0 || a_rm !== 32'h0) begin miscompares++; $display("FAIL noop_write: bfv %h sel %b wm %h rm %h want 1 1000 0 0", a_bfv, a_sel, a_wm, a_rm); end
    endtask

    task automatic test_read_clear;
        issue(8'h08, 1'b0, 32'h0, 4'h0);
        vectors++; if (a_bfv !== 1'b1 || a_sel !== 4'b0100) begin miscompares++; $display("FAIL rc_strobe: bfv %h sel %b want 1 0100", a_bfv, a_sel); end
        vectors++; if (a_rm !== 32'hFFFF_FFFF || a_wm !== 32'h0) begin miscompares++; $display("FAIL rc_masks: rm %h wm %h want ffffffff 0", a_rm, a_wm); end
        vectors++; if (r_valid !== 1'b1 || r_err !== 1'b0 || r_rd !== 32'h0000_00F0) begin miscompares++; $display("FAIL rc_resp: valid %h err %h rd %h want 1 0 000000f0", r_valid, r_err, r_rd); end
        issue(8'h08, 1'b0, 32'h0, 4'h0);
        vectors++; if (r_rd !== 32'h0) begin miscompares++; $display("FAIL rc_cleared: got %h want 0", r_rd); end
    endtask

    task automatic test_errors;
        logic [7:0] bad [2];
        bad = '{8'h10, 8'h06};
        for (int i = 0; i < 2; i++) begin
            issue(bad[i], 1'b0, 32'h0, 4'h0);
            vectors++; if (r_err !== 1'b1 || r_rd !== 32'h0 || a_bfv !== 1'b0 || bfv_delta !== 0) begin miscompares++; $display("FAIL err_%h: err %h rd %h bfv %h strobes %0d want 1 0 0 0", bad[i], r_err, r_rd, a_bfv, bfv_delta); end
        end
        // BASE = 0x20 instance: below base, then a mapped address
        issue(8'h1C, 1'b0, 32'h0, 4'h0);
        vectors++; if (r_b_err !== 1'b1 || r_b_rd !== 32'h0 || a_b_bfv !== 1'b0) begin miscompares++; $display("FAIL err_underflow: err %h rd %h bfv %h want 1 0 0", r_b_err, r_b_rd, a_b_bfv); end
        issue(8'h24, 1'b0, 32'h0, 4'h0);
        vectors++; if (r_b_err !== 1'b0 || r_b_rd !== 32'h2222_2222 || a_b_bfv !== 1'b1) begin miscompares++; $display("FAIL base_read: err %h rd %h bfv %h want 0 22222222 1", r_b_err, r_b_rd, a_b_bfv); end
    endtask

    task automatic test_back_pressure;
        int c0;
        @(negedge clk);
        req_valid = 1'b1; write = 1'b0; address = 8'h00; c0 = bfv_count;
        @(negedge clk);
        vectors++; if (bfv !== 1'b1 || sel !== 4'b0001) begin miscompares++; $display("FAIL bp_strobe: bfv %h sel %b want 1 0001", bfv, sel); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (resp_valid !== 1'b1 || rdata !== 32'h1111_1111 || err !== 1'b0 || req_ready !== 1'b0 || bfv !== 1'b0) begin miscompares++; $display("FAIL bp_hold_%0d: rv %h rd %h err %h rr %h bfv %h want 1 11111111 0 0 0", k, resp_valid, rdata, err, req_ready, bfv); end
        end
        vectors++; if (bfv_count - c0 !== 1) begin miscompares++; $display("FAIL bp_strobe_count: got %0d want 1", bfv_count - c0); end
        @(negedge clk);
        resp_ready = 1'b1; address = 8'h04;
        @(negedge clk);
        resp_ready = 1'b0;
        vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || bfv !== 1'b0) begin miscompares++; $display("FAIL bp_release: rr %h rv %h bfv %h want 1 0 0", req_ready, resp_valid, bfv); end
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (bfv !== 1'b1 || sel !== 4'b0010) begin miscompares++; $display("FAIL bp_next_accept: bfv %h sel %b want 1 0010", bfv, sel); end
        @(negedge clk);
        vectors++; if (rdata !== 32'h2222_2222) begin miscompares++; $display("FAIL bp_next_resp: got %h want 22222222", rdata); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_rd [4];
        time t_last;
        exp_rd = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h4444_4444};
        t_last = 0;
        @(negedge clk);
        resp_ready = 1'b1; req_valid = 1'b1; write = 1'b0; address = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (bfv !== 1'b1 || sel !== 4'(1 << i)) begin miscompares++; $display("FAIL b2b_strobe_%0d: bfv %h sel %b want 1 %b", i, bfv, sel, 4'(1 << i)); end
            if (i > 0) begin
                vectors++; if ($time - t_last !== 30) begin miscompares++; $display("FAIL b2b_spacing_%0d: got %0t want 30", i, $time - t_last); end
            end
            t_last = $time;
            if (i == 3) req_valid = 1'b0; else address = 8'((i + 1) * 4);
            @(negedge clk);
            vectors++; if (resp_valid !== 1'b1 || rdata !== exp_rd[i]) begin miscompares++; $display("FAIL b2b_resp_%0d: rv %h rd %h want 1 %h", i, resp_valid, rdata, exp_rd[i]); end
            @(negedge clk);
        end
        resp_ready = 1'b0;
        vectors++; if (b2b_seen !== 1'b0) begin miscompares++; $display("FAIL strobe_adjacent: got %h want 0", b2b_seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; address = '0; write = 1'b0;
        wdata = '0; strobe = '0; resp_ready = 1'b0;
        test_reset();
        test_write();
        test_read_clear();
        test_errors();
        test_back_pressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
